// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: forwarding selects,
// load-use/branch/MDU stalls, flushes, post-reset bubble and multiply/divide tracking.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       JumpD,
  input  logic       PCSrcD,
  input  logic       MdReqD,
  input  logic       MdStartE,
  input  logic       MdIsDivE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MdBusy,
  output logic       MdDone,
  output logic       MdOverlapErr
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MD_BUSY = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic lwstall_s, branchstall_s, mdstall_s, stall_s, cnt_zero_s;

  // $0 is hard-wired, so it never produces a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic wm,
                                         input logic [4:0] rm, input logic ww,
                                         input logic [4:0] rw);
    logic [1:0] sel;
    if (wm && reg_match(rm, src)) begin
      sel = 2'b10;
    end else if (ww && reg_match(rw, src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Forwarding selects, M stage has priority over W.
  always_comb begin
    ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    ForwardAD = RegWriteM && reg_match(WriteRegM, RsD);
    ForwardBD = RegWriteM && reg_match(WriteRegM, RtD);
  end

  // Stall sources.
  always_comb begin
    cnt_zero_s    = (cnt_q == CNT_ZERO);
    lwstall_s     = MemtoRegE && (reg_match(RtE, RsD) || reg_match(RtE, RtD));
    branchstall_s = BranchD &&
                    ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                     (MemtoRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
    mdstall_s     = (state_q == MD_BUSY) && MdReqD && !cnt_zero_s;
    stall_s       = lwstall_s || branchstall_s || mdstall_s;
  end

  // Pipeline control outputs; a stalled F/D register ignores its clear, so flush waits.
  always_comb begin
    StallF = 1'b1;
    StallD = 1'b0;
    FlushD = 1'b1;
    FlushE = 1'b1;
    case (state_q)
      RUN, MD_BUSY: begin
        StallF = stall_s;
        StallD = stall_s;
        FlushE = stall_s;
        FlushD = (PCSrcD || JumpD) && !stall_s;
      end
      BOOT: begin
        StallF = 1'b1;
        StallD = 1'b0;
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      default: begin
        StallF = 1'b1;
        StallD = 1'b0;
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
    endcase
    MdBusy       = (state_q == MD_BUSY);
    MdDone       = (state_q == MD_BUSY) && cnt_zero_s;
    MdOverlapErr = err_q;
  end

  // Next state: boot bubble, then MDU countdown with back-to-back reload on the done cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        cnt_d   = CNT_ZERO;
      end
      RUN: begin
        if (MdStartE) begin
          state_d = MD_BUSY;
          cnt_d   = MdIsDivE ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = RUN;
        end
      end
      MD_BUSY: begin
        if (cnt_zero_s) begin
          if (MdStartE) begin
            state_d = MD_BUSY;
            cnt_d   = MdIsDivE ? DIV_LOAD : MULT_LOAD;
          end else begin
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (MdStartE) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
      end
      default: begin
        state_d = BOOT;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      cnt_q   <= CNT_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a cycle-count based model.
module tb_pipe_hazard_ctrl;

  localparam int MULT_CYCLES = 4;
  localparam int DIV_CYCLES  = 32;

  logic clk, rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, JumpD, PCSrcD, MdReqD, MdStartE, MdIsDivE;
  logic StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic MdBusy, MdDone, MdOverlapErr;

  int n_checks = 0;
  int n_err    = 0;

  // Model: boot flag, and the absolute cycle number at which the MDU result is valid.
  bit boot_m, md_active_m, err_m;
  int done_cyc_m, cyc;

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD),
    .MdReqD(MdReqD), .MdStartE(MdStartE), .MdIsDivE(MdIsDivE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MdBusy(MdBusy), .MdDone(MdDone), .MdOverlapErr(MdOverlapErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic int fwd_m(input logic [4:0] src);
    if (RegWriteM && dep(WriteRegM, src)) return 2;
    if (RegWriteW && dep(WriteRegW, src)) return 1;
    return 0;
  endfunction

  task automatic compare_all();
    bit at_done, lw, br, md, st;
    at_done = md_active_m && (cyc == done_cyc_m);
    lw = MemtoRegE && (dep(RtE, RsD) || dep(RtE, RtD));
    br = BranchD && ((RegWriteE && (dep(WriteRegE, RsD) || dep(WriteRegE, RtD))) ||
                     (MemtoRegM && (dep(WriteRegM, RsD) || dep(WriteRegM, RtD))));
    md = md_active_m && MdReqD && !at_done;
    st = lw || br || md;
    chk("ForwardAE", int'(ForwardAE), fwd_m(RsE));
    chk("ForwardBE", int'(ForwardBE), fwd_m(RtE));
    chk("ForwardAD", int'(ForwardAD), int'(RegWriteM && dep(WriteRegM, RsD)));
    chk("ForwardBD", int'(ForwardBD), int'(RegWriteM && dep(WriteRegM, RtD)));
    chk("StallF", int'(StallF), boot_m ? 1 : int'(st));
    chk("StallD", int'(StallD), boot_m ? 0 : int'(st));
    chk("FlushE", int'(FlushE), boot_m ? 1 : int'(st));
    chk("FlushD", int'(FlushD), boot_m ? 1 : int'((PCSrcD || JumpD) && !st));
    chk("MdBusy", int'(MdBusy), int'(md_active_m));
    chk("MdDone", int'(MdDone), int'(at_done));
    chk("MdOverlapErr", int'(MdOverlapErr), int'(err_m));
  endtask

  task automatic model_update();
    bit at_done;
    at_done = md_active_m && (cyc == done_cyc_m);
    if (rst_n) begin
      if (boot_m) begin
        boot_m = 1'b0;
      end else if (MdStartE && (!md_active_m || at_done)) begin
        md_active_m = 1'b1;
        done_cyc_m  = cyc + (MdIsDivE ? DIV_CYCLES : MULT_CYCLES);
      end else if (at_done) begin
        md_active_m = 1'b0;
      end else if (MdStartE && md_active_m) begin
        err_m = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic model_reset();
    boot_m = 1'b1;
    md_active_m = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic step_check();
    @(negedge clk);
    compare_all();
  endtask

  task automatic step_adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
    WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    BranchD = 1'b0; JumpD = 1'b0; PCSrcD = 1'b0;
    MdReqD = 1'b0; MdStartE = 1'b0; MdIsDivE = 1'b0;
  endtask

  task automatic md_latency(input bit is_div, input int exp_stalls, input string name);
    int stalls;
    bit seen;
    stalls = 0;
    seen = 1'b0;
    set_idle();
    MdStartE = 1'b1; MdIsDivE = is_div;
    step_check();
    step_adv();
    MdStartE = 1'b0; MdIsDivE = 1'b0; MdReqD = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      step_check();
      if (MdDone) begin
        seen = 1'b1;
        chk({name, "_stall_at_done"}, int'(StallD), 0);
      end else if (StallD) begin
        stalls++;
      end
      step_adv();
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    chk({name, "_stall_cycles"}, stalls, exp_stalls);
    set_idle();
    step_check();
    chk({name, "_idle_after"}, int'(MdBusy), 0);
    step_adv();
  endtask

  initial begin
    cyc = 0;
    done_cyc_m = 0;
    model_reset();
    rst_n = 1'b0;
    set_idle();

    // Reset state
    step_check(); step_adv();
    step_check();
    chk("rst_StallF", int'(StallF), 1);
    chk("rst_FlushD", int'(FlushD), 1);
    chk("rst_FlushE", int'(FlushE), 1);
    chk("rst_StallD", int'(StallD), 0);
    chk("rst_MdBusy", int'(MdBusy), 0);
    step_adv();
    rst_n = 1'b1;
    step_check();
    chk("boot_StallF", int'(StallF), 1);
    chk("boot_FlushD", int'(FlushD), 1);
    chk("boot_FlushE", int'(FlushE), 1);
    step_adv();
    step_check();
    chk("run_StallF", int'(StallF), 0);
    chk("run_FlushD", int'(FlushD), 0);
    chk("run_FlushE", int'(FlushE), 0);
    step_adv();

    // Load-use stall, then forward from M
    MemtoRegE = 1'b1; RtE = 5'd8; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
    step_check();
    chk("lw_StallF", int'(StallF), 1);
    chk("lw_StallD", int'(StallD), 1);
    chk("lw_FlushE", int'(FlushE), 1);
    step_adv();
    set_idle();
    MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd8; RsE = 5'd8;
    step_check();
    chk("lw_fwdAE", int'(ForwardAE), 2);
    chk("lw_released", int'(StallD), 0);
    step_adv();

    // Forward priority
    set_idle();
    RegWriteM = 1'b1; RegWriteW = 1'b1; WriteRegM = 5'd5; WriteRegW = 5'd5; RsE = 5'd5;
    step_check(); chk("fwd_m_prio", int'(ForwardAE), 2); step_adv();
    WriteRegM = 5'd0;
    step_check(); chk("fwd_w", int'(ForwardAE), 1); step_adv();
    RsE = 5'd0; WriteRegW = 5'd0;
    step_check(); chk("fwd_r0", int'(ForwardAE), 0); step_adv();

    // MDU latency
    md_latency(1'b1, DIV_CYCLES - 1, "div");
    md_latency(1'b0, MULT_CYCLES - 1, "mult");

    // Branch hazard suppresses flush, then flush when released
    set_idle();
    BranchD = 1'b1; PCSrcD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RsD = 5'd9;
    step_check();
    chk("br_FlushD_held", int'(FlushD), 0);
    chk("br_stall", int'(StallD), 1);
    step_adv();
    RegWriteE = 1'b0;
    step_check();
    chk("br_FlushD", int'(FlushD), 1);
    chk("br_nostall", int'(StallD), 0);
    step_adv();

    // Overlap error, then reset mid-divide
    set_idle();
    MdStartE = 1'b1; MdIsDivE = 1'b1;
    step_check(); step_adv();
    step_check(); step_adv();
    MdStartE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_check();
      chk("ovl_err", int'(MdOverlapErr), 1);
      chk("ovl_busy", int'(MdBusy), 1);
      step_adv();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_busy", int'(MdBusy), 0);
    chk("rst_mid_done", int'(MdDone), 0);
    chk("rst_mid_err", int'(MdOverlapErr), 0);
    step_check(); step_adv();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step_check(); step_adv();
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = 1'($urandom_range(0, 3) == 0); MemtoRegM = 1'($urandom_range(0, 3) == 0);
      BranchD = 1'($urandom_range(0, 3) == 0); JumpD = 1'($urandom_range(0, 7) == 0);
      PCSrcD = 1'($urandom_range(0, 2) == 0);
      MdReqD = 1'($urandom_range(0, 1)); MdStartE = 1'($urandom_range(0, 11) == 0);
      MdIsDivE = 1'($urandom_range(0, 2) == 0);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      step_check();
      step_adv();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
